// File: rtl/output_port_arbiter_pkg.sv
// output_port_arbiter_pkg: shared packet layout, direction indices and sizing helper for the router output stage.
package output_port_arbiter_pkg;
  localparam int PKT_WIDTH = 64;
  localparam int DIR_X_BIT = 58;
  localparam int DIR_Y_BIT = 57;
  localparam int HOP_X_HI = 56;
  localparam int HOP_X_LO = 55;
  localparam int HOP_Y_HI = 54;
  localparam int HOP_Y_LO = 53;
  typedef enum logic [2:0] {DIR_N, DIR_S, DIR_E, DIR_W, DIR_PE} dir_e;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/output_port_arbiter_if.sv
// output_port_arbiter_if: source-side req/packet/full bundle plus link-side output and debug signals.
interface output_port_arbiter_if import output_port_arbiter_pkg::*; #(
  parameter int PKT_W = PKT_WIDTH,
  parameter int NUM_SRC = 4
);
  localparam int TW = idx_w(NUM_SRC);
  logic [NUM_SRC-1:0] req_in;
  logic [NUM_SRC*PKT_W-1:0] packet_in;
  logic [NUM_SRC-1:0] full_out;
  logic [PKT_W-1:0] out_packet;
  logic out_valid;
  logic link_full;
  logic [TW-1:0] token;
  logic proto_err;
  modport slave(input req_in, packet_in, link_full, output full_out, out_packet, out_valid, token, proto_err);
  modport master(output req_in, packet_in, link_full, input full_out, out_packet, out_valid, token, proto_err);
endinterface

// File: rtl/output_port_arbiter_sync_fifo.sv
// sync_fifo: first-word-fall-through register FIFO; contents survive reset, only pointers and count clear.
module sync_fifo #(
  parameter int W = 64,
  parameter int DEPTH = 4
)(
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic [W-1:0] din,
  input  logic pop,
  output logic [W-1:0] dout,
  output logic [$clog2(DEPTH):0] count,
  output logic empty,
  output logic full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk)
    if (do_push && !reset) mem[wr_ptr] <= din;
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_ptr + AW'(do_pop);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/output_port_arbiter.sv
// output_port_arbiter: rotating-token single-push-per-cycle arbiter feeding an output FIFO with link backpressure.
module output_port_arbiter import output_port_arbiter_pkg::*; #(
  parameter int PKT_W = PKT_WIDTH,
  parameter int NUM_SRC = 4,
  parameter int DEPTH = 4
)(
  input logic clk,
  input logic reset,
  output_port_arbiter_if.slave bus
);
  localparam int TW = idx_w(NUM_SRC);
  localparam int CW = $clog2(DEPTH) + 1;
  logic [TW-1:0] tok;
  logic [NUM_SRC-1:0] full;
  logic [CW-1:0] count;
  logic fifo_full, empty, push, pop, perr;
  logic [PKT_W-1:0] din;
  // full_out comes only from registers so a source's req never loops back into its own full
  always_comb begin
    full = '1;
    for (int i = 0; i < NUM_SRC; i++) full[i] = (tok != TW'(i)) || (count == CW'(DEPTH));
  end
  assign push = bus.req_in[tok] && !fifo_full;
  assign pop = !empty && !bus.link_full;
  assign din = bus.packet_in[tok*PKT_W +: PKT_W];
  always_ff @(posedge clk) begin
    if (reset) begin
      tok <= '0;
      perr <= 1'b0;
    end else begin
      tok <= (tok == TW'(NUM_SRC-1)) ? '0 : tok + TW'(1);
      perr <= perr | (|(bus.req_in & full));
    end
  end
  sync_fifo #(.W(PKT_W), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .reset(reset), .push(push), .din(din), .pop(pop),
    .dout(bus.out_packet), .count(count), .empty(empty), .full(fifo_full)
  );
  assign bus.full_out = full;
  assign bus.out_valid = !empty;
  assign bus.token = tok;
  assign bus.proto_err = perr;
endmodule

// File: tb/tb_output_port_arbiter.sv
// tb_output_port_arbiter: queue-based reference model drives sources; monitor pops a scoreboard on every DUT pop.
module tb_output_port_arbiter;
  import output_port_arbiter_pkg::*;
  localparam int NS = 4;
  localparam int D = 4;
  localparam int W = 64;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  output_port_arbiter_if #(.PKT_W(W), .NUM_SRC(NS)) bus();
  output_port_arbiter #(.PKT_W(W), .NUM_SRC(NS), .DEPTH(D)) dut(.clk(clk), .reset(reset), .bus(bus.slave));
  logic [W-1:0] sb[$];
  logic [W-1:0] src_q[NS][$];
  int errors = 0, checks = 0;
  int m_tok = 0, m_cnt = 0;
  bit m_err = 0, illegal2 = 0;

  function automatic void chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  task automatic step(input bit rst_v, input bit lf);
    logic [NS-1:0] req, exp_full;
    logic [W-1:0] pk [NS];
    bit push, pop;
    @(negedge clk);
    #1;
    for (int i = 0; i < NS; i++) exp_full[i] = (i != m_tok) || (m_cnt == D);
    chk("token", W'(bus.token), W'(m_tok));
    chk("out_valid", W'(bus.out_valid), W'(m_cnt > 0));
    chk("proto_err", W'(bus.proto_err), W'(m_err));
    chk("full_out", W'(bus.full_out), W'(exp_full));
    chk("count", W'(dut.count), W'(m_cnt));
    reset = rst_v;
    bus.link_full = lf;
    for (int i = 0; i < NS; i++) begin
      req[i] = !rst_v && src_q[i].size() > 0 && !bus.full_out[i];
      pk[i] = src_q[i].size() > 0 ? src_q[i][0] : '0;
    end
    if (illegal2 && m_tok == 0 && !rst_v) begin
      req[2] = 1'b1;
      pk[2] = 64'h0BAD;
    end
    bus.req_in = req;
    for (int i = 0; i < NS; i++) bus.packet_in[i*W +: W] = pk[i];
    if (rst_v) begin
      m_tok = 0;
      m_cnt = 0;
      m_err = 0;
      sb.delete();
    end else begin
      push = req[m_tok] && m_cnt < D;
      pop = m_cnt > 0 && !lf;
      for (int i = 0; i < NS; i++) if (req[i] && (i != m_tok || m_cnt == D)) m_err = 1;
      if (push) begin
        sb.push_back(pk[m_tok]);
        void'(src_q[m_tok].pop_front());
      end
      m_cnt = m_cnt + int'(push) - int'(pop);
      m_tok = (m_tok + 1) % NS;
    end
  endtask

  task automatic restart();
    for (int i = 0; i < NS; i++) src_q[i].delete();
    illegal2 = 0;
    step(1, 0);
  endtask

  initial begin
    logic [W-1:0] exp;
    forever begin
      @(negedge clk);
      #3;
      if (!reset && bus.out_valid === 1'b1 && !bus.link_full) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL out_packet: got %h expected no output", bus.out_packet);
        end else begin
          exp = sb.pop_front();
          chk("out_packet", bus.out_packet, exp);
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    bus.req_in = '0;
    bus.packet_in = '0;
    bus.link_full = 1'b0;
    repeat (2) @(posedge clk);
    restart();
    src_q[0].push_back(64'h0400_0000_0000_00AA);
    repeat (10) step(0, 0);
    restart();
    for (int i = 0; i < NS; i++) src_q[i].push_back(W'(i + 1));
    repeat (10) step(0, 0);
    restart();
    for (int i = 0; i < NS; i++) repeat (4) src_q[i].push_back({$urandom, $urandom});
    repeat (12) step(0, 1);
    repeat (30) step(0, 0);
    restart();
    illegal2 = 1;
    repeat (3) step(0, 0);
    illegal2 = 0;
    repeat (4) step(0, 0);
    restart();
    repeat (300) begin
      if ($urandom_range(0, 2) != 0) src_q[$urandom_range(0, NS-1)].push_back({$urandom, $urandom});
      step(0, $urandom_range(0, 3) == 0);
    end
    restart();
    for (int i = 0; i < 3; i++) src_q[i].push_back(W'(64'hC0 + i));
    repeat (6) step(0, 1);
    step(1, 1);
    src_q[0].push_back(64'h0000_0000_0000_0F1F);
    repeat (8) step(0, 0);
    repeat (10) step(0, 0);
    chk("sb_drained", W'(sb.size()), '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
